// File: rtl/ppu_op_scheduler.sv
// ============================================================================
// Module   : ppu_op_scheduler
// Purpose  : Round-robin sharing of one variable-latency posit core between
//            two requesters, with a watchdog that answers NaR on core stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppu_op_scheduler #(
    parameter int N       = 16,
    parameter int OP_SIZE = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*OP_SIZE-1:0]   req_op,
    input  logic [2*N-1:0]         req_p1,
    input  logic [2*N-1:0]         req_p2,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [N-1:0]           rsp_result,
    output logic                   rsp_err,
    output logic                   core_start,
    output logic [OP_SIZE-1:0]     core_op,
    output logic [N-1:0]           core_p1,
    output logic [N-1:0]           core_p2,
    input  logic                   core_done,
    input  logic [N-1:0]           core_result
);

    localparam logic [OP_SIZE-1:0] OP_ADD = OP_SIZE'(0);
    localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] OP_MUL = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] OP_DIV = OP_SIZE'(3);
    localparam int                 WD_W   = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0]    WD_MAX = WD_W'(TIMEOUT - 1);
    localparam logic [N-1:0]       NAR    = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               grant_q, grant_d;
    logic [OP_SIZE-1:0] op_q, op_d;
    logic [N-1:0]       p1_q, p1_d;
    logic [N-1:0]       p2_q, p2_d;
    logic [N-1:0]       result_q, result_d;
    logic               err_q, err_d;
    logic [WD_W-1:0]    wd_q, wd_d;

    logic               win;
    logic [OP_SIZE-1:0] win_op;
    logic               win_legal;
    logic [WD_W-1:0]    wd_inc;

    // With both requesters pending the pointer decides, otherwise the lone one wins.
    assign win       = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    assign win_op    = win ? req_op[2*OP_SIZE-1:OP_SIZE] : req_op[OP_SIZE-1:0];
    assign win_legal = (win_op == OP_ADD) || (win_op == OP_SUB) ||
                       (win_op == OP_MUL) || (win_op == OP_DIV);
    assign wd_inc    = wd_q + WD_W'(1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        op_d       = op_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        result_d   = result_q;
        err_d      = err_q;
        wd_d       = wd_q;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        core_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready = win ? 2'b10 : 2'b01;
                    grant_d   = win;
                    ptr_d     = ~win;
                    op_d      = win_op;
                    p1_d      = win ? req_p1[2*N-1:N] : req_p1[N-1:0];
                    p2_d      = win ? req_p2[2*N-1:N] : req_p2[N-1:0];
                    if (win_legal) begin
                        state_d = ISSUE;
                    end else begin
                        result_d = NAR;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                wd_d       = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // A completion in the final watchdog cycle still takes precedence.
                if (core_done) begin
                    result_d = core_result;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (wd_inc == WD_MAX) begin
                    wd_d     = wd_inc;
                    result_d = NAR;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    wd_d = wd_inc;
                end
            end
            RESP: begin
                rsp_valid = grant_q ? 2'b10 : 2'b01;
                if (rsp_ready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            grant_q  <= 1'b0;
            op_q     <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            result_q <= result_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end

    assign core_op    = op_q;
    assign core_p1    = p1_q;
    assign core_p2    = p2_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ppu_op_scheduler.sv
// ============================================================================
// Module   : tb_ppu_op_scheduler
// Purpose  : Transaction-timeline model of the scheduler driving directed and
//            random traffic plus a responding core model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ppu_op_scheduler;

    localparam int N   = 16;
    localparam int OPS = 3;
    localparam int T   = 64;
    localparam logic [2:0] C_ADD = 3'd0;
    localparam logic [2:0] C_SUB = 3'd1;
    localparam logic [2:0] C_MUL = 3'd2;
    localparam logic [2:0] C_ILL = 3'd7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [2*OPS-1:0] req_op = '0;
    logic [2*N-1:0]  req_p1 = '0;
    logic [2*N-1:0]  req_p2 = '0;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready = '0;
    logic [N-1:0]    rsp_result;
    logic            rsp_err;
    logic            core_start;
    logic [OPS-1:0]  core_op;
    logic [N-1:0]    core_p1;
    logic [N-1:0]    core_p2;
    logic            core_done = 1'b0;
    logic [N-1:0]    core_result = '0;

    ppu_op_scheduler #(.N(N), .OP_SIZE(OPS), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_p1(req_p1), .req_p2(req_p2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .core_start(core_start), .core_op(core_op),
        .core_p1(core_p1), .core_p2(core_p2),
        .core_done(core_done), .core_result(core_result)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: a transaction accepted at cycle c starts at c+1; its response
    // appears at start+L+1 if the core answers in time, else at start+T.
    bit          m_busy = 1'b0;
    bit          m_ptr = 1'b0;
    bit          m_grant = 1'b0;
    bit          m_legal = 1'b0;
    bit          m_err = 1'b0;
    logic [2:0]  m_op = '0;
    logic [15:0] m_p1 = '0, m_p2 = '0, m_res = '0, m_core_val = '0;
    int          m_start = 0, m_lat = 0, m_resp = 0;
    int          next_lat = 1;
    logic [15:0] next_val = '0;
    int          grants[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] rand_op();
        return ($urandom_range(0, 7) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
    endfunction

    task automatic step(input logic [1:0] rv, input logic [5:0] ops, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] rr, input bit spur);
        logic [1:0] exp_rr;
        logic [1:0] exp_rv;
        bit         spur_ok;
        bit         idx;
        req_valid = rv; req_op = ops; req_p1 = a; req_p2 = b; rsp_ready = rr;
        spur_ok = !m_busy || !m_legal || (cyc == m_start) || (cyc >= m_resp);
        if (m_busy && m_legal && m_lat != 0 && cyc == m_start + m_lat) begin
            core_done = 1'b1; core_result = m_core_val;
        end else if (spur && spur_ok) begin
            core_done = 1'b1; core_result = 16'($urandom);
        end else begin
            core_done = 1'b0; core_result = 16'($urandom);
        end

        if (m_busy)           exp_rr = 2'b00;
        else if (rv == 2'b11) exp_rr = m_ptr ? 2'b10 : 2'b01;
        else                  exp_rr = rv;
        exp_rv = (m_busy && cyc >= m_resp) ? (m_grant ? 2'b10 : 2'b01) : 2'b00;

        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_rr));
        chk("core_start", 32'(core_start), 32'(m_busy && m_legal && cyc == m_start));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("core_regs", {core_op, core_p1[12:0], core_p2}, {m_op, m_p1[12:0], m_p2});
        chk("core_p1_hi", 32'(core_p1[15:13]), 32'(m_p1[15:13]));
        if (exp_rv != 2'b00) begin
            chk("rsp_result", 32'(rsp_result), 32'(m_res));
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end

        if (!m_busy && exp_rr != 2'b00) begin
            idx     = exp_rr[1];
            m_grant = idx;
            m_ptr   = ~idx;
            m_op    = idx ? ops[5:3] : ops[2:0];
            m_p1    = idx ? a[31:16] : a[15:0];
            m_p2    = idx ? b[31:16] : b[15:0];
            m_legal = (m_op < 3'd4);
            m_busy  = 1'b1;
            grants.push_back(int'(idx));
            if (m_legal) begin
                m_start    = cyc + 1;
                m_lat      = next_lat;
                m_core_val = next_val;
                if (m_lat != 0 && m_lat <= T - 1) begin
                    m_resp = m_start + m_lat + 1; m_res = m_core_val; m_err = 1'b0;
                end else begin
                    m_resp = m_start + T; m_res = 16'h8000; m_err = 1'b1;
                end
            end else begin
                m_resp = cyc + 1; m_res = 16'h8000; m_err = 1'b1;
            end
        end else if (m_busy && cyc >= m_resp && rr[m_grant]) begin
            m_busy = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && m_busy; k++) step(2'b00, '0, '0, '0, 2'b11, 1'b0);
        chk("drain_idle", 32'(m_busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"}, 32'(req_ready), 32'd0);
        chk({name, "_start"}, 32'(core_start), 32'd0);
        chk({name, "_valid"}, 32'(rsp_valid), 32'd0);
        chk({name, "_err"}, 32'(rsp_err), 32'd0);
        chk({name, "_result"}, 32'(rsp_result), 32'd0);
        chk({name, "_core"}, {core_op, core_p1[12:0], core_p2}, 32'd0);
        chk({name, "_p1hi"}, 32'(core_p1[15:13]), 32'd0);
    endtask

    initial begin
        int g0;
        #2;
        chk_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Fairness: both requesters always pending, core latency 1.
        next_lat = 1;
        g0 = grants.size();
        for (int k = 0; k < 40 && grants.size() < g0 + 4; k++)
            step(2'b11, {C_MUL, C_ADD}, $urandom, $urandom, 2'b11, 1'b0);
        chk("fair_count", 32'(grants.size() - g0), 32'd4);
        if (grants.size() >= g0 + 4) begin
            chk("fair_order", {8'(grants[g0]), 8'(grants[g0+1]), 8'(grants[g0+2]), 8'(grants[g0+3])},
                32'h00010001);
        end
        drain();

        // Single ADD with a three-cycle core.
        next_lat = 3; next_val = 16'h5000;
        g0 = cyc;
        step(2'b01, {C_ILL, C_ADD}, 32'h0000_4000, 32'h0000_4000, 2'b00, 1'b0);
        chk("single_start", 32'(m_start - g0), 32'd1);
        chk("single_resp", 32'(m_resp - g0), 32'd5);
        chk("single_res", 32'(m_res), 32'h5000);
        for (int k = 0; k < 6; k++) step(2'b00, '0, '0, '0, 2'b00, 1'b0);
        step(2'b00, '0, '0, '0, 2'b01, 1'b0);
        chk("single_done", 32'(m_busy), 32'd0);

        // Backpressure on requester 1 while requester 0 keeps asking.
        next_lat = 1; next_val = 16'h1234;
        step(2'b10, {C_SUB, C_ADD}, 32'h3000_1000, 32'h2000_0100, 2'b00, 1'b0);
        for (int k = 0; k < 2; k++) step(2'b11, {C_SUB, C_ADD}, $urandom, $urandom, 2'b01, 1'b0);
        for (int k = 0; k < 10; k++) step(2'b11, {C_SUB, C_ADD}, $urandom, $urandom, 2'b01, 1'b0);
        chk("bp_held", 32'(m_busy), 32'd1);
        step(2'b11, {C_SUB, C_ADD}, $urandom, $urandom, 2'b10, 1'b0);
        step(2'b11, {C_SUB, C_ADD}, $urandom, $urandom, 2'b00, 1'b0);
        chk("bp_next_grant", 32'(m_grant), 32'd0);
        drain();

        // Illegal opcode answers immediately with NaR.
        g0 = cyc;
        step(2'b01, {C_ADD, C_ILL}, $urandom, $urandom, 2'b00, 1'b0);
        chk("ill_resp", 32'(m_resp - g0), 32'd1);
        chk("ill_err", 32'(m_err), 32'd1);
        step(2'b00, '0, '0, '0, 2'b01, 1'b0);
        drain();

        // Timeout, with stray core_done pulses in RESP and IDLE.
        next_lat = 0;
        step(2'b01, {C_ADD, C_MUL}, $urandom, $urandom, 2'b00, 1'b0);
        chk("to_resp", 32'(m_resp - m_start), 32'd64);
        for (int k = 0; k < 70; k++) step(2'b00, '0, '0, '0, 2'b00, k >= 66);
        step(2'b00, '0, '0, '0, 2'b01, 1'b1);
        for (int k = 0; k < 3; k++) step(2'b00, '0, '0, '0, 2'b00, 1'b1);

        // Boundary latencies: last legal cycle, and one too late.
        next_lat = T - 1; next_val = 16'h2222;
        step(2'b01, {C_ADD, C_ADD}, $urandom, $urandom, 2'b00, 1'b0);
        chk("edge_err", 32'(m_err), 32'd0);
        drain();
        next_lat = T; next_val = 16'h3333;
        step(2'b10, {C_ADD, C_ADD}, $urandom, $urandom, 2'b00, 1'b0);
        chk("late_err", 32'(m_err), 32'd1);
        drain();

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            if (!m_busy) begin
                case ($urandom_range(0, 19))
                    0:       next_lat = 0;
                    1:       next_lat = T - 1;
                    2:       next_lat = T;
                    default: next_lat = $urandom_range(1, 6);
                endcase
                next_val = 16'($urandom);
            end
            step(2'($urandom_range(0, 3)), {rand_op(), rand_op()}, $urandom, $urandom,
                 2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
        end
        drain();

        // Asynchronous reset while waiting on the core.
        next_lat = 0;
        step(2'b10, {C_MUL, C_ADD}, 32'hABCD_1111, 32'h1357_2222, 2'b00, 1'b0);
        for (int k = 0; k < 5; k++) step(2'b00, '0, '0, '0, 2'b00, 1'b0);
        core_done = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("mid_reset");
        m_busy = 1'b0; m_ptr = 1'b0; m_op = '0; m_p1 = '0; m_p2 = '0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cyc++;
        next_lat = 2; next_val = 16'h0F0F;
        step(2'b11, {C_SUB, C_ADD}, $urandom, $urandom, 2'b00, 1'b0);
        chk("post_reset_grant", 32'(m_grant), 32'd0);
        for (int k = 0; k < 3; k++) step(2'b00, '0, '0, '0, 2'b00, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
